// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: default sizes, 2-bit
// saturating counter encodings and the helpers that step those counters.
package bp_pkg;

    localparam int BP_ADDR_W = 5;
    localparam int BP_IDX_W  = 4;
    localparam int BP_CNT_W  = 16;

    // Two-bit history counter states; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_e;

    // Step a counter towards strongly taken, holding at the top.
    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'b01;
    endfunction

    // Step a counter towards strongly not-taken, holding at the bottom.
    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'b01;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped storage of {valid, tag, target, counter} entries.
// The fetch side reads asynchronously; execute feedback writes on the clock
// edge. A second asynchronous read port lets the trainer see the entry it is
// about to modify. Reads never see a same-cycle write.
module bp_table
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int IDX_W  = BP_IDX_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IDX_W-1:0]        lk_idx_i,
    output logic                    lk_valid_o,
    output logic [ADDR_W-IDX_W-1:0] lk_tag_o,
    output logic [ADDR_W-1:0]       lk_target_o,
    output logic [1:0]              lk_cnt_o,
    input  logic [IDX_W-1:0]        up_idx_i,
    output logic                    up_valid_o,
    output logic [ADDR_W-IDX_W-1:0] up_tag_o,
    output logic [ADDR_W-1:0]       up_target_o,
    output logic [1:0]              up_cnt_o,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic                    wr_valid_i,
    input  logic [ADDR_W-IDX_W-1:0] wr_tag_i,
    input  logic [ADDR_W-1:0]       wr_target_i,
    input  logic [1:0]              wr_cnt_i
);

    localparam int TAG_W   = ADDR_W - IDX_W;
    localparam int ENTRIES = 2 ** IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q[ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];

    // Fetch-side and training-side reads are plain array lookups.
    always_comb begin
        lk_valid_o  = valid_q[lk_idx_i];
        lk_tag_o    = tag_q[lk_idx_i];
        lk_target_o = target_q[lk_idx_i];
        lk_cnt_o    = cnt_q[lk_idx_i];
        up_valid_o  = valid_q[up_idx_i];
        up_tag_o    = tag_q[up_idx_i];
        up_target_o = target_q[up_idx_i];
        up_cnt_o    = cnt_q[up_idx_i];
    end

    // Clear every entry to weak not-taken on reset, otherwise apply one write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= WNT;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i]  <= wr_valid_i;
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            cnt_q[wr_idx_i]    <= wr_cnt_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor in front of instruction fetch: BTB plus 2-bit history
// table lookup, training from execute feedback, registered mispredict
// redirect, and saturating branch / mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int IDX_W  = BP_IDX_W,
    parameter int CNT_W  = BP_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mis_count
);

    localparam int TAG_W = ADDR_W - IDX_W;

    logic              lkValid;
    logic [TAG_W-1:0]  lkTag;
    logic [ADDR_W-1:0] lkTarget;
    logic [1:0]        lkCnt;
    logic              upValid;
    logic [TAG_W-1:0]  upTag;
    logic [ADDR_W-1:0] upTarget;
    logic [1:0]        upCnt;

    logic              wrEn;
    logic              wrValid;
    logic [TAG_W-1:0]  wrTag;
    logic [ADDR_W-1:0] wrTarget;
    logic [1:0]        wrCnt;

    logic              lookupHit;
    logic              updateHit;
    logic              misNow;

    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [CNT_W-1:0]  brCount_q, brCount_d;
    logic [CNT_W-1:0]  misCount_q, misCount_d;

    bp_table #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .lk_idx_i    (fetch_pc[IDX_W-1:0]),
        .lk_valid_o  (lkValid),
        .lk_tag_o    (lkTag),
        .lk_target_o (lkTarget),
        .lk_cnt_o    (lkCnt),
        .up_idx_i    (ex_pc[IDX_W-1:0]),
        .up_valid_o  (upValid),
        .up_tag_o    (upTag),
        .up_target_o (upTarget),
        .up_cnt_o    (upCnt),
        .wr_en_i     (wrEn),
        .wr_idx_i    (ex_pc[IDX_W-1:0]),
        .wr_valid_i  (wrValid),
        .wr_tag_i    (wrTag),
        .wr_target_i (wrTarget),
        .wr_cnt_i    (wrCnt)
    );

    // Zero-latency prediction; a miss falls through to the next sequential word.
    always_comb begin
        lookupHit   = lkValid && (lkTag == fetch_pc[ADDR_W-1:IDX_W]);
        pred_taken  = lookupHit && lkCnt[1];
        pred_target = lookupHit ? lkTarget : fetch_pc + ADDR_W'(1);
    end

    // Training: hits move the counter, taken misses allocate weak-taken.
    always_comb begin
        updateHit = upValid && (upTag == ex_pc[ADDR_W-1:IDX_W]);
        wrEn      = 1'b0;
        wrValid   = upValid;
        wrTag     = upTag;
        wrTarget  = upTarget;
        wrCnt     = upCnt;
        if (ex_valid) begin
            if (updateHit) begin
                wrEn = 1'b1;
                if (ex_taken) begin
                    wrCnt    = sat_inc2(upCnt);
                    wrTarget = ex_target;
                end else begin
                    wrCnt = sat_dec2(upCnt);
                end
            end else if (ex_taken) begin
                wrEn     = 1'b1;
                wrValid  = 1'b1;
                wrTag    = ex_pc[ADDR_W-1:IDX_W];
                wrTarget = ex_target;
                wrCnt    = WT;
            end
        end
    end

    // Mispredict detection, redirect address and saturating statistics.
    always_comb begin
        misNow = ex_valid && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_target != ex_pred_target)));
        mispredict_d = misNow;
        redirect_d   = redirect_q;
        brCount_d    = brCount_q;
        misCount_d   = misCount_q;
        if (misNow) begin
            redirect_d = ex_taken ? ex_target : ex_pc + ADDR_W'(1);
        end
        if (ex_valid && (brCount_q != '1)) begin
            brCount_d = brCount_q + CNT_W'(1);
        end
        if (misNow && (misCount_q != '1)) begin
            misCount_d = misCount_q + CNT_W'(1);
        end
    end

    // Register the fetch redirect and the statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            brCount_q    <= '0;
            misCount_q   <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            brCount_q    <= brCount_d;
            misCount_q   <= misCount_d;
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;
    assign br_count    = brCount_q;
    assign mis_count   = misCount_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver issues one cycle of
// stimulus at each falling edge and queues the predicted lookup and
// registered responses; two monitors pop and compare them.
module tb_branch_predictor;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam int NPC    = 32;
    localparam int NENT   = 16;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] fetch_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  mis_count;

    branch_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mis_count      (mis_count)
    );

    // 10-unit clock; stimulus changes on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int fpc;
        int taken;
        int target;
    } lookExp_t;

    typedef struct {
        int mis;
        int redir;
        int br;
        int mc;
    } seqExp_t;

    lookExp_t lookQ[$];
    seqExp_t  seqQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model: a map keyed by index holding owner address, target,
    // and an integer confidence 0..3 (taken when >= 2).
    bit mValid[NENT];
    int mOwner[NENT];
    int mTarget[NENT];
    int mConf[NENT];
    int mRedirect;
    int mBr;
    int mMis;
    bit modelKnown = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int modelPredTaken(input int pc);
        int i = pc % NENT;
        return (mValid[i] && mOwner[i] == pc && mConf[i] >= 2) ? 1 : 0;
    endfunction

    function automatic int modelPredTarget(input int pc);
        int i = pc % NENT;
        return (mValid[i] && mOwner[i] == pc) ? mTarget[i] : (pc + 1) % NPC;
    endfunction

    // Drive one cycle, queue what the DUT must show, then advance the model.
    task automatic applyStimulus(input bit rst, input int fpc, input bit exv,
                                 input int pc, input bit tk, input int tgt,
                                 input bit ptk, input int ptgt);
        lookExp_t le;
        seqExp_t  se;
        int       i;
        bit       mis;
        @(negedge clk);
        reset          = rst;
        fetch_pc       = ADDR_W'(fpc);
        ex_valid       = exv;
        ex_pc          = ADDR_W'(pc);
        ex_taken       = tk;
        ex_target      = ADDR_W'(tgt);
        ex_pred_taken  = ptk;
        ex_pred_target = ADDR_W'(ptgt);
        if (modelKnown) begin
            le.fpc    = fpc;
            le.taken  = modelPredTaken(fpc);
            le.target = modelPredTarget(fpc);
            lookQ.push_back(le);
        end
        if (rst) begin
            for (int k = 0; k < NENT; k++) begin
                mValid[k] = 0; mOwner[k] = 0; mTarget[k] = 0; mConf[k] = 1;
            end
            mRedirect  = 0;
            mBr        = 0;
            mMis       = 0;
            modelKnown = 1;
            se.mis     = 0;
        end else begin
            mis = exv && ((tk != ptk) || (tk && tgt != ptgt));
            if (exv) begin
                i = pc % NENT;
                if (mValid[i] && mOwner[i] == pc) begin
                    if (tk) begin
                        mConf[i]   = (mConf[i] < 3) ? mConf[i] + 1 : 3;
                        mTarget[i] = tgt;
                    end else begin
                        mConf[i] = (mConf[i] > 0) ? mConf[i] - 1 : 0;
                    end
                end else if (tk) begin
                    mValid[i] = 1; mOwner[i] = pc; mTarget[i] = tgt; mConf[i] = 2;
                end
                if (mBr < 65535) mBr++;
            end
            if (mis) begin
                mRedirect = tk ? tgt : (pc + 1) % NPC;
                if (mMis < 65535) mMis++;
            end
            se.mis = mis ? 1 : 0;
        end
        se.redir = mRedirect;
        se.br    = mBr;
        se.mc    = mMis;
        seqQ.push_back(se);
    endtask

    // Lookup monitor: prediction outputs settle before the next rising edge.
    initial begin
        lookExp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (lookQ.size() > 0) begin
                e = lookQ.pop_front();
                checkOutput($sformatf("pred_taken(pc=%0d)", e.fpc), 32'(pred_taken), e.taken);
                checkOutput($sformatf("pred_target(pc=%0d)", e.fpc), 32'(pred_target), e.target);
            end
        end
    end

    // Registered-output monitor: sampled just after each rising edge.
    initial begin
        seqExp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (seqQ.size() > 0) begin
                e = seqQ.pop_front();
                checkOutput("mispredict", 32'(mispredict), e.mis);
                checkOutput("redirect_pc", 32'(redirect_pc), e.redir);
                checkOutput("br_count", 32'(br_count), e.br);
                checkOutput("mis_count", 32'(mis_count), e.mc);
            end
        end
    end

    initial begin
        int pc, tgt, ptk, ptgt;
        bit tk;
        reset = 1'b1; fetch_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
        ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

        // Reset, then cold lookups.
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0);
        // Allocate pc 6 -> 30 with a not-taken prediction: mispredict.
        applyStimulus(0, 6, 1, 6, 1, 30, 0, 0);
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0);
        // Two correct taken updates, then two not-taken mispredicts.
        applyStimulus(0, 6, 1, 6, 1, 30, 1, 30);
        applyStimulus(0, 6, 1, 6, 1, 30, 1, 30);
        applyStimulus(0, 6, 1, 6, 0, 0, 1, 30);
        applyStimulus(0, 6, 1, 6, 0, 0, 1, 30);
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0);
        // Not-taken at the top address wraps the redirect to 0.
        applyStimulus(0, 6, 1, 31, 0, 0, 1, 12);
        // Aliasing pc 22 shares the index of pc 6.
        applyStimulus(0, 22, 0, 0, 0, 0, 0, 0);
        // Wrong predicted target on a taken branch.
        applyStimulus(0, 22, 1, 6, 1, 9, 1, 30);
        // Same-cycle lookup and update of pc 6: old contents shown.
        applyStimulus(0, 6, 1, 6, 1, 17, 0, 0);
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0);
        // Reset beats a concurrent update.
        applyStimulus(1, 6, 1, 6, 1, 3, 0, 0);
        applyStimulus(0, 6, 0, 0, 0, 0, 0, 0);

        // Random traffic on a small pc range so entries alias and retrain.
        for (int n = 0; n < 400; n++) begin
            pc   = $urandom_range(0, 7) * 4 + $urandom_range(0, 1);
            tk   = $urandom_range(0, 2) != 0;
            tgt  = $urandom_range(0, NPC - 1);
            if ($urandom_range(0, 1) == 1) begin
                ptk  = modelPredTaken(pc);
                ptgt = modelPredTarget(pc);
            end else begin
                ptk  = $urandom_range(0, 1);
                ptgt = $urandom_range(0, NPC - 1);
            end
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, NPC - 1),
                          $urandom_range(0, 3) != 0, pc, tk, tgt, ptk[0], ptgt);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
